// File: rtl/ps2_hex_input_ctrl.sv
// ps2_hex_input_ctrl
//   Sequences PS/2 make codes through an external registered scan-code-to-ASCII
//   decoder and accumulates hexadecimal key presses into a 32-bit word. The word
//   is handed to the processor on Enter with a valid/ack handshake.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   read_req      in   processor is waiting on an input instruction (level)
//   scan_valid    in   one-cycle strobe qualifying scan_code
//   scan_code     in   raw PS/2 Set 2 byte
//   dec_scan_code out  registered code presented to the decoder
//   ascii_in      in   decoder ASCII output (one cycle after dec_scan_code)
//   data_out      out  accumulated value, newest digit in bits [3:0]
//   data_valid    out  data_out is final; held until cpu_ack
//   cpu_ack       in   one-cycle strobe; processor consumed data_out
//   digit_count   out  digits entered this request, saturating at MAX_DIGITS
//   overrun       out  sticky; a scan byte was dropped while busy
//   busy          out  high while a code is inside the decoder pipeline
module ps2_hex_input_ctrl #(
  parameter int MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_req,
  input  logic        scan_valid,
  input  logic [7:0]  scan_code,
  output logic [7:0]  dec_scan_code,
  input  logic [7:0]  ascii_in,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        cpu_ack,
  output logic [3:0]  digit_count,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_BREAK, S_EXT, S_LOOKUP, S_APPLY, S_DONE
  } state_t;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [3:0] MAX_CNT    = 4'(MAX_DIGITS);

  state_t state, state_next;

  // The decoder passes unmapped codes through raw, so its output alone cannot
  // tell a real hex key from e.g. 'N' (31h -> '1') or Tab (0Dh -> CR).
  function automatic logic is_hex_key(input logic [7:0] code);
    case (code)
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
      8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h5A: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  logic       key_ok;
  logic       is_digit;
  logic       is_enter;
  logic [3:0] nibble;
  logic       active;
  logic       abort;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    is_digit = 1'b0;
    nibble   = 4'h0;
    if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = 4'(ascii_in - 8'h30);
    end else if (ascii_in >= 8'h41 && ascii_in <= 8'h46) begin
      is_digit = 1'b1;
      nibble   = 4'(ascii_in - 8'h37);
    end
  end

  assign key_ok   = is_hex_key(dec_scan_code);
  assign is_enter = key_ok && (ascii_in == 8'h0D);
  assign active   = (state != S_IDLE) && (state != S_DONE);
  // Withdrawing the request abandons the entry everywhere except DONE.
  assign abort    = active && !read_req;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:    if (read_req) state_next = S_COLLECT;
        S_COLLECT: if (scan_valid) begin
                     if (scan_code == CODE_BREAK)    state_next = S_BREAK;
                     else if (scan_code == CODE_EXT) state_next = S_EXT;
                     else                            state_next = S_LOOKUP;
                   end
        S_BREAK:   if (scan_valid) state_next = S_COLLECT;
        S_EXT:     if (scan_valid) begin
                     if (scan_code == CODE_BREAK)      state_next = S_BREAK;
                     else if (scan_code == CODE_ENTER) state_next = S_LOOKUP;
                     else                              state_next = S_COLLECT;
                   end
        S_LOOKUP:  state_next = S_APPLY;
        S_APPLY:   state_next = (is_enter && digit_count != 4'd0) ? S_DONE : S_COLLECT;
        S_DONE:    if (cpu_ack) state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state == S_LOOKUP) || (state == S_APPLY);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      digit_count   <= '0;
      overrun       <= 1'b0;
      dec_scan_code <= 8'h00;
    end else begin
      if (busy && scan_valid) overrun <= 1'b1;

      if (abort) begin
        data_out    <= '0;
        digit_count <= '0;
      end else begin
        unique case (state)
          S_IDLE: if (read_req) begin
            data_out    <= '0;
            digit_count <= '0;
            overrun     <= 1'b0;
          end
          S_COLLECT: if (scan_valid && scan_code != CODE_BREAK && scan_code != CODE_EXT)
            dec_scan_code <= scan_code;
          S_EXT: if (scan_valid && scan_code == CODE_ENTER)
            dec_scan_code <= CODE_ENTER;
          S_APPLY: if (key_ok) begin
            if (is_digit) begin
              // Oldest nibble falls off the top once more than 8 digits arrive.
              data_out <= {data_out[27:0], nibble};
              if (digit_count != MAX_CNT) digit_count <= digit_count + 4'd1;
            end else if (is_enter && digit_count != 4'd0) begin
              data_valid <= 1'b1;
            end
          end
          S_DONE: if (cpu_ack) data_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
